// File: rtl/data_memory_responder.sv
// data_memory_responder: word-addressed data memory answering one CPU request at a time.
// Ports: clk, reset (async, active-high); req_valid/req_ready/req_write/req_addr/req_wdata/req_be
//        request channel; resp_valid/resp_ready/resp_rdata/resp_err response channel.
module data_memory_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

    localparam logic [31:0]   DEPTH_W    = 32'(DEPTH);
    localparam logic [CW-1:0] COUNT_LOAD = (LATENCY > 2) ? CW'(LATENCY - 2) : '0;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] count;
    logic          settle;

    logic          op_write;
    logic [31:0]   op_addr;
    logic [31:0]   op_wdata;
    logic [3:0]    op_be;

    logic [31:0]   mem [DEPTH];

    logic          accept;
    logic          enter_resp;
    logic          commit;
    logic          a_write;
    logic [31:0]   a_addr;
    logic [31:0]   a_wdata;
    logic [3:0]    a_be;
    logic          a_err;
    logic [AW-1:0] a_idx;

    // settle blocks the first IDLE cycle after a response so a new
    // request is never taken on the same edge the old one retires.
    assign req_ready = (state == IDLE) && !settle;
    assign accept    = req_ready && req_valid && !reset;

    // With LATENCY=1 the access happens on the accept edge itself, so it
    // must see the live request instead of the captured copy.
    always_comb begin
        if (state == IDLE) begin
            a_write = req_write;
            a_addr  = req_addr;
            a_wdata = req_wdata;
            a_be    = req_be;
        end else begin
            a_write = op_write;
            a_addr  = op_addr;
            a_wdata = op_wdata;
            a_be    = op_be;
        end
    end

    assign a_err = (a_addr[1:0] != 2'b00) || ({2'b00, a_addr[31:2]} >= DEPTH_W);
    assign a_idx = a_addr[AW+1:2];

    always_comb begin
        enter_resp = 1'b0;
        if (state == BUSY && count == '0) begin
            enter_resp = 1'b1;
        end
        if (accept && LATENCY == 1) begin
            enter_resp = 1'b1;
        end
    end

    assign commit = enter_resp && a_write && !a_err && !reset;

    // Storage is never reset; only the gated commit edge writes it.
    always_ff @(posedge clk) begin
        if (commit) begin
            if (a_be[0]) mem[a_idx][7:0]   <= a_wdata[7:0];
            if (a_be[1]) mem[a_idx][15:8]  <= a_wdata[15:8];
            if (a_be[2]) mem[a_idx][23:16] <= a_wdata[23:16];
            if (a_be[3]) mem[a_idx][31:24] <= a_wdata[31:24];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            settle     <= 1'b0;
            op_write   <= 1'b0;
            op_addr    <= '0;
            op_wdata   <= '0;
            op_be      <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            settle <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_write <= req_write;
                        op_addr  <= req_addr;
                        op_wdata <= req_wdata;
                        op_be    <= req_be;
                        if (LATENCY == 1) begin
                            state <= RESP;
                        end else begin
                            state <= BUSY;
                            count <= COUNT_LOAD;
                        end
                    end
                end
                BUSY: begin
                    if (count == '0) begin
                        state <= RESP;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        settle     <= 1'b1;
                        resp_valid <= 1'b0;
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
            if (enter_resp) begin
                resp_valid <= 1'b1;
                resp_err   <= a_err;
                resp_rdata <= (a_write || a_err) ? 32'h0 : mem[a_idx];
            end
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: three responders (LATENCY 2, 1, 4) against a
// cycle-count transaction model, plus directed literal scenarios.
module tb_data_memory_responder;

    logic        clk;
    logic        reset      [3];
    logic        req_valid  [3];
    logic        req_ready  [3];
    logic        req_write  [3];
    logic [31:0] req_addr   [3];
    logic [31:0] req_wdata  [3];
    logic [3:0]  req_be     [3];
    logic        resp_valid [3];
    logic        resp_ready [3];
    logic [31:0] resp_rdata [3];
    logic        resp_err   [3];

    int checks;
    int errors;
    int cyc;

    function automatic int lat_of(int u);
        if (u == 0) return 2;
        if (u == 1) return 1;
        return 4;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        data_memory_responder #(
            .DEPTH  (256),
            .LATENCY((g == 0) ? 2 : ((g == 1) ? 1 : 4))
        ) dut (
            .clk       (clk),
            .reset     (reset[g]),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_write (req_write[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .req_be    (req_be[g]),
            .resp_valid(resp_valid[g]),
            .resp_ready(resp_ready[g]),
            .resp_rdata(resp_rdata[g]),
            .resp_err  (resp_err[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s timeout waiting for DUT", nm);
    endtask

    // Transaction model: one outstanding request, response visible from
    // edge (accept + LATENCY - 1), one blocked cycle after each handshake.
    logic        m_out  [3];
    logic        m_vis  [3];
    logic        m_cool [3];
    logic        m_dc   [3];
    logic        m_err  [3];
    logic [31:0] m_data [3];
    int          m_acc  [3];
    logic        m_w    [3];
    logic [31:0] m_a    [3];
    logic [31:0] m_wd   [3];
    logic [3:0]  m_be   [3];
    logic [31:0] mm     [3][256];
    logic        mk     [3][256];

    function automatic void model_commit(int u);
        int  w;
        logic bad;
        w   = int'(m_a[u][31:2]);
        bad = (m_a[u][1:0] != 2'b00) || (m_a[u][31:2] >= 30'd256);
        m_vis[u] = 1'b1;
        m_dc[u]  = 1'b0;
        m_data[u] = 32'h0;
        m_err[u]  = bad;
        if (!bad) begin
            if (m_w[u]) begin
                for (int i = 0; i < 4; i++)
                    if (m_be[u][i]) mm[u][w][8*i +: 8] = m_wd[u][8*i +: 8];
                if (m_be[u] == 4'hF) mk[u][w] = 1'b1;
            end else begin
                m_data[u] = mm[u][w];
                m_dc[u]   = !mk[u][w];
            end
        end
    endfunction

    function automatic void model_step(int u);
        logic hs;
        logic ac;
        if (reset[u]) begin
            m_out[u]  = 1'b0;
            m_vis[u]  = 1'b0;
            m_cool[u] = 1'b0;
            return;
        end
        hs = m_out[u] && m_vis[u] && resp_ready[u];
        ac = !m_out[u] && !m_cool[u] && req_valid[u];
        if (hs) begin
            m_out[u]  = 1'b0;
            m_vis[u]  = 1'b0;
            m_cool[u] = 1'b1;
        end else if (m_cool[u]) begin
            m_cool[u] = 1'b0;
        end else if (ac) begin
            m_out[u] = 1'b1;
            m_acc[u] = cyc;
            m_w[u]   = req_write[u];
            m_a[u]   = req_addr[u];
            m_wd[u]  = req_wdata[u];
            m_be[u]  = req_be[u];
        end
        if (m_out[u] && !m_vis[u] && cyc == m_acc[u] + lat_of(u) - 1)
            model_commit(u);
    endfunction

    initial begin
        cyc = 0;
        for (int u = 0; u < 3; u++) begin
            m_out[u] = 0; m_vis[u] = 0; m_cool[u] = 0; m_dc[u] = 0;
            m_err[u] = 0; m_data[u] = 0; m_acc[u] = 0;
            for (int i = 0; i < 256; i++) mk[u][i] = 1'b0;
        end
        forever begin
            @(posedge clk);
            cyc++;
            for (int u = 0; u < 3; u++) model_step(u);
        end
    end

    // Compare process: every cycle, every unit.
    initial begin
        forever begin
            @(negedge clk);
            for (int u = 0; u < 3; u++) begin
                logic        er;
                logic        ev;
                logic        ee;
                logic [31:0] ed;
                if (reset[u]) begin
                    er = 1'b1; ev = 1'b0; ee = 1'b0; ed = 32'h0;
                end else begin
                    er = !m_out[u] && !m_cool[u];
                    ev = m_vis[u];
                    ee = m_vis[u] && m_err[u];
                    ed = m_vis[u] ? m_data[u] : 32'h0;
                end
                check($sformatf("u%0d req_ready c%0d", u, cyc), 32'(req_ready[u]), 32'(er));
                check($sformatf("u%0d resp_valid c%0d", u, cyc), 32'(resp_valid[u]), 32'(ev));
                check($sformatf("u%0d resp_err c%0d", u, cyc), 32'(resp_err[u]), 32'(ee));
                if (!(ev && m_dc[u]))
                    check($sformatf("u%0d resp_rdata c%0d", u, cyc), resp_rdata[u], ed);
            end
        end
    end

    task automatic do_req(input int u, input logic w, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be, input int hold,
                          output logic [31:0] rd, output logic er, output int lat);
        int n;
        rd = 32'h0; er = 1'b0; lat = -1;
        @(posedge clk); #2;
        req_valid[u] = 1'b1; req_write[u] = w; req_addr[u] = a;
        req_wdata[u] = wd; req_be[u] = be;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready[u] && n < 50);
        if (!req_ready[u]) begin
            timeout($sformatf("u%0d accept", u));
            req_valid[u] = 1'b0;
            return;
        end
        @(posedge clk); #2;
        req_valid[u] = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!resp_valid[u] && n < 50);
        if (!resp_valid[u]) begin
            timeout($sformatf("u%0d response", u));
            return;
        end
        lat = n;
        rd  = resp_rdata[u];
        er  = resp_err[u];
        repeat (hold) @(negedge clk);
        @(posedge clk); #2;
        resp_ready[u] = 1'b1;
        @(posedge clk); #2;
        resp_ready[u] = 1'b0;
    endtask

    // Accepts a request, then asserts reset d cycles after the accept edge.
    task automatic req_then_reset(input int u, input logic [31:0] a,
                                  input logic [31:0] wd, input int d);
        int n;
        @(posedge clk); #2;
        req_valid[u] = 1'b1; req_write[u] = 1'b1; req_addr[u] = a;
        req_wdata[u] = wd; req_be[u] = 4'hF;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready[u] && n < 50);
        if (!req_ready[u]) timeout($sformatf("u%0d rst accept", u));
        @(posedge clk); #2;
        req_valid[u] = 1'b0;
        repeat (d) @(posedge clk);
        #2;
        reset[u] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("u%0d valid in reset", u), 32'(resp_valid[u]), 32'h0);
        end
        @(posedge clk); #2;
        reset[u] = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          hits [$];

    initial begin
        #500000;
        $display("FAIL global watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        for (int u = 0; u < 3; u++) begin
            reset[u] = 1'b1; req_valid[u] = 0; req_write[u] = 0; req_addr[u] = 0;
            req_wdata[u] = 0; req_be[u] = 0; resp_ready[u] = 0;
        end
        repeat (3) @(posedge clk);
        #2;
        for (int u = 0; u < 3; u++) reset[u] = 1'b0;

        // Store/load round trip, LATENCY 2.
        do_req(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat);
        check("st latency", 32'(lat), 32'd2);
        check("st rdata", rd, 32'h0);
        check("st err", 32'(er), 32'h0);
        do_req(0, 0, 32'h10, 32'h0, 4'h0, 1, rd, er, lat);
        check("ld latency", 32'(lat), 32'd2);
        check("ld rdata", rd, 32'hDEADBEEF);
        check("ld err", 32'(er), 32'h0);

        // Partial byte-lane store.
        do_req(0, 1, 32'h10, 32'hAABBCCDD, 4'b0101, 0, rd, er, lat);
        do_req(0, 0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
        check("be0101 rdata", rd, 32'hDEBBBEDD);

        // Empty byte mask is acknowledged and changes nothing.
        do_req(0, 1, 32'h10, 32'h12345678, 4'h0, 0, rd, er, lat);
        check("be0000 err", 32'(er), 32'h0);
        check("be0000 latency", 32'(lat), 32'd2);

        // Error cases.
        do_req(0, 0, 32'h12, 32'h0, 4'h0, 0, rd, er, lat);
        check("misaligned err", 32'(er), 32'h1);
        check("misaligned rdata", rd, 32'h0);
        do_req(0, 0, 32'h400, 32'h0, 4'h0, 0, rd, er, lat);
        check("range err", 32'(er), 32'h1);
        check("range rdata", rd, 32'h0);
        do_req(0, 1, 32'h12, 32'h11111111, 4'hF, 0, rd, er, lat);
        check("misaligned st err", 32'(er), 32'h1);
        do_req(0, 1, 32'h410, 32'h22222222, 4'hF, 0, rd, er, lat);
        check("range st err", 32'(er), 32'h1);
        do_req(0, 0, 32'h3FC, 32'h0, 4'h0, 0, rd, er, lat);
        check("last word err", 32'(er), 32'h0);
        do_req(0, 0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
        check("mem unchanged", rd, 32'hDEBBBEDD);

        // Back-pressure with req_valid held high.
        @(posedge clk); #2;
        req_valid[0] = 1; req_write[0] = 0; req_addr[0] = 32'h10;
        begin
            int n;
            n = 0;
            do begin @(negedge clk); n++; end while (!req_ready[0] && n < 50);
            if (!req_ready[0]) timeout("bp accept");
            n = 0;
            do begin @(negedge clk); n++; end while (!resp_valid[0] && n < 50);
            if (!resp_valid[0]) timeout("bp response");
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp rdata stable", resp_rdata[0], 32'hDEBBBEDD);
            check("bp req_ready", 32'(req_ready[0]), 32'h0);
        end
        @(posedge clk); #2;
        resp_ready[0] = 1;
        @(posedge clk); #2;
        resp_ready[0] = 0;
        @(negedge clk);
        check("bp idle gap ready", 32'(req_ready[0]), 32'h0);
        check("bp idle gap valid", 32'(resp_valid[0]), 32'h0);
        @(negedge clk);
        check("bp ready after gap", 32'(req_ready[0]), 32'h1);
        @(posedge clk); #2;
        req_valid[0] = 0;
        @(negedge clk);
        check("bp second accept", 32'(req_ready[0]), 32'h0);
        repeat (2) @(negedge clk);
        check("bp second rdata", resp_rdata[0], 32'hDEBBBEDD);
        @(posedge clk); #2;
        resp_ready[0] = 1;
        @(posedge clk); #2;
        resp_ready[0] = 0;

        // Reset in RESP keeps the committed store.
        req_then_reset(0, 32'h18, 32'hCAFEF00D, 2);
        do_req(0, 0, 32'h18, 32'h0, 4'h0, 0, rd, er, lat);
        check("rst in resp keeps", rd, 32'hCAFEF00D);

        // Reset in BUSY drops the pending store, LATENCY 4.
        do_req(2, 1, 32'h20, 32'h1, 4'hF, 0, rd, er, lat);
        check("lat4 latency", 32'(lat), 32'd4);
        req_then_reset(2, 32'h20, 32'h55, 1);
        do_req(2, 0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat);
        check("rst in busy drops", rd, 32'h1);

        // LATENCY 1 back-to-back with resp_ready tied high.
        do_req(1, 1, 32'h8, 32'h12345678, 4'hF, 0, rd, er, lat);
        check("lat1 latency", 32'(lat), 32'd1);
        @(posedge clk); #2;
        resp_ready[1] = 1; req_valid[1] = 1; req_write[1] = 0; req_addr[1] = 32'h8;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (resp_valid[1]) begin
                hits.push_back(cyc);
                check("b2b rdata", resp_rdata[1], 32'h12345678);
            end
        end
        @(posedge clk); #2;
        req_valid[1] = 0;
        repeat (4) @(posedge clk);
        #2;
        resp_ready[1] = 0;
        check("b2b count", 32'(hits.size()), 32'd10);
        for (int k = 1; k < hits.size(); k++)
            check("b2b period", 32'(hits[k] - hits[k-1]), 32'd3);

        // Randomized traffic on every unit.
        for (int u = 0; u < 3; u++) begin
            for (int i = 0; i < 8; i++)
                do_req(u, 1, 32'h40 + 32'(i * 4), $urandom, 4'hF, 0, rd, er, lat);
            for (int i = 0; i < 40; i++) begin
                int          sel;
                logic [31:0] a;
                sel = int'($urandom_range(0, 9));
                if (sel < 7)       a = 32'h40 + 32'($urandom_range(0, 7) * 4);
                else if (sel == 7) a = 32'h3FC;
                else if (sel == 8) a = 32'h40 + 32'($urandom_range(1, 3));
                else               a = 32'h400 + 32'($urandom_range(0, 63) * 4);
                do_req(u, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                       int'($urandom_range(0, 3)), rd, er, lat);
                check($sformatf("u%0d rand latency", u), 32'(lat), 32'(lat_of(u)));
            end
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
